// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, flag indices, condition codes
// and the mul/div sequencer state encoding.
package alu_pkg;

    localparam int ALU_W = 12;

    localparam logic [4:0] OP_NOP = 5'h00;
    localparam logic [4:0] OP_MOV = 5'h01;
    localparam logic [4:0] OP_AND = 5'h02;
    localparam logic [4:0] OP_OR  = 5'h03;
    localparam logic [4:0] OP_ADD = 5'h04;
    localparam logic [4:0] OP_ADC = 5'h05;
    localparam logic [4:0] OP_SUB = 5'h06;
    localparam logic [4:0] OP_XOR = 5'h07;
    localparam logic [4:0] OP_RKL = 5'h0A;
    localparam logic [4:0] OP_RKR = 5'h0B;
    localparam logic [4:0] OP_SHL = 5'h0C;
    localparam logic [4:0] OP_SHR = 5'h0D;

    localparam int FLG_Z = 0;
    localparam int FLG_S = 1;
    localparam int FLG_K = 2;
    localparam int FLG_V = 3;
    localparam int FLG_P = 4;

    localparam logic [3:0] CC_EQ  = 4'h0;
    localparam logic [3:0] CC_NE  = 4'h1;
    localparam logic [3:0] CC_KS  = 4'h2;
    localparam logic [3:0] CC_KC  = 4'h3;
    localparam logic [3:0] CC_ALW = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_M_ADD,
        S_M_RH,
        S_M_RL,
        S_D_SHL,
        S_D_RKL,
        S_D_SUB,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// alu_muldiv_seq_if: CPU-side issue/result handshake
// for the multiply/divide sequencer.
interface alu_muldiv_seq_if #(
    parameter int W = 12
);
    logic         start;
    logic         op_div;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] res_hi;
    logic [W-1:0] res_lo;

    modport master (
        output start, op_div, opa, opb,
        input  busy, done, div_zero, res_hi, res_lo
    );

    modport slave (
        input  start, op_div, opa, opb,
        output busy, done, div_zero, res_hi, res_lo
    );

endinterface

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: 12x12 multiply / 12/12 restoring divide on
// the shared ALU. ALU_MULDIV_ABORT_EN adds an abort input.
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int W     = 12,
    parameter int CNT_W = 4
) (
    input  logic            clk,
    input  logic            rst,
`ifdef ALU_MULDIV_ABORT_EN
    input  logic            abort,
`endif
    alu_muldiv_seq_if.slave cpu,
    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    output logic [4:0]      alu_op,
    output logic [4:0]      alu_flg_in,
    output logic [3:0]      alu_cond,
    input  logic [W-1:0]    alu_q,
    input  logic [4:0]      alu_flg_out
);

    seq_state_t       state, state_nxt;
    logic [W-1:0]     hi, hi_nxt;
    logic [W-1:0]     lo, lo_nxt;
    logic [W-1:0]     hi_sh, hsh_nxt;
    logic [W-1:0]     opnd, opnd_nxt;
    logic             k, k_nxt;
    logic             ovf, ovf_nxt;
    logic [CNT_W-1:0] count, cnt_nxt;
    logic             dz, dz_nxt;
    logic [W-1:0]     res_hi, res_lo;
    logic             k_in, k_out, last;
    logic             unused_flg;

    assign k_out      = alu_flg_out[FLG_K];
    assign unused_flg = ^{alu_flg_out[4:3], alu_flg_out[1:0]};
    assign last       = (count == CNT_W'(W - 1));
    assign alu_cond   = CC_ALW;

    always_comb begin
        alu_flg_in        = '0;
        alu_flg_in[FLG_K] = k_in;
    end

    assign cpu.busy     = (state != S_IDLE);
    assign cpu.done     = (state == S_DONE);
    assign cpu.div_zero = dz;
    assign cpu.res_hi   = res_hi;
    assign cpu.res_lo   = res_lo;

    always_comb begin
        state_nxt = state;
        hi_nxt    = hi;
        lo_nxt    = lo;
        hsh_nxt   = hi_sh;
        opnd_nxt  = opnd;
        k_nxt     = k;
        ovf_nxt   = ovf;
        cnt_nxt   = count;
        dz_nxt    = dz;
        alu_op    = OP_NOP;
        alu_a     = '0;
        alu_b     = '0;
        k_in      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (cpu.start) begin
                    opnd_nxt = cpu.op_div ? cpu.opb : cpu.opa;
                    cnt_nxt  = '0;
                    dz_nxt   = 1'b0;
                    hi_nxt   = '0;
                    if (!cpu.op_div) begin
                        lo_nxt    = cpu.opb;
                        state_nxt = S_M_ADD;
                    end else if (cpu.opb != '0) begin
                        lo_nxt    = cpu.opa;
                        state_nxt = S_D_SHL;
                    end else begin
                        hi_nxt    = cpu.opa;
                        lo_nxt    = '1;
                        dz_nxt    = 1'b1;
                        state_nxt = S_DONE;
                    end
                end
            end
            S_M_ADD: begin
                alu_op    = OP_ADD;
                alu_a     = hi;
                alu_b     = lo[0] ? opnd : '0;
                k_in      = k;
                hi_nxt    = alu_q;
                k_nxt     = k_out;
                state_nxt = S_M_RH;
            end
            S_M_RH: begin
                alu_op    = OP_RKR;
                alu_b     = hi;
                k_in      = k;
                hi_nxt    = alu_q;
                k_nxt     = k_out;
                state_nxt = S_M_RL;
            end
            S_M_RL: begin
                alu_op    = OP_RKR;
                alu_b     = lo;
                k_in      = k;
                lo_nxt    = alu_q;
                cnt_nxt   = count + 1'b1;
                state_nxt = last ? S_DONE : S_M_ADD;
            end
            S_D_SHL: begin
                alu_op    = OP_SHL;
                alu_b     = lo;
                k_in      = k;
                lo_nxt    = alu_q;
                k_nxt     = k_out;
                state_nxt = S_D_RKL;
            end
            S_D_RKL: begin
                alu_op    = OP_RKL;
                alu_b     = hi;
                k_in      = k;
                hsh_nxt   = alu_q;
                ovf_nxt   = k_out;
                state_nxt = S_D_SUB;
            end
            S_D_SUB: begin
                alu_op  = OP_SUB;
                alu_a   = hi_sh;
                alu_b   = opnd;
                k_in    = k;
                // ovf: true remainder exceeds W bits, so it always fits
                if (ovf || !k_out) begin
                    hi_nxt    = alu_q;
                    lo_nxt[0] = 1'b1;
                end else begin
                    hi_nxt = hi_sh;
                end
                cnt_nxt   = count + 1'b1;
                state_nxt = last ? S_DONE : S_D_SHL;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
`ifdef ALU_MULDIV_ABORT_EN
        if (abort && state != S_IDLE && state != S_DONE) begin
            state_nxt = S_IDLE;
            dz_nxt    = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            hi     <= '0;
            lo     <= '0;
            hi_sh  <= '0;
            opnd   <= '0;
            k      <= 1'b0;
            ovf    <= 1'b0;
            count  <= '0;
            dz     <= 1'b0;
            res_hi <= '0;
            res_lo <= '0;
        end else begin
            state <= state_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            hi_sh <= hsh_nxt;
            opnd  <= opnd_nxt;
            k     <= k_nxt;
            ovf   <= ovf_nxt;
            count <= cnt_nxt;
            dz    <= dz_nxt;
            // results only move on the way into DONE
            if (state_nxt == S_DONE) begin
                res_hi <= hi_nxt;
                res_lo <= lo_nxt;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: vector table plus scoreboard for the
// mul/div sequencer, with a behavioural model of the ALU.
module tb_alu_muldiv_seq;
    import alu_pkg::*;

    typedef struct {
        logic        d;
        logic [11:0] a;
        logic [11:0] b;
        logic [11:0] eh;
        logic [11:0] el;
        logic        ez;
        int          lat;
    } vec_t;

    typedef struct {
        logic [11:0] eh;
        logic [11:0] el;
        logic        ez;
        int          lat;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] alu_a, alu_b, alu_q;
    logic [4:0]  alu_op, alu_flg_in, alu_flg_out;
    logic [3:0]  alu_cond;
    logic [12:0] r;
`ifdef ALU_MULDIV_ABORT_EN
    logic        abort = 1'b0;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    alu_muldiv_seq_if #(.W(12)) cpu ();

    alu_muldiv_seq #(.W(12), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef ALU_MULDIV_ABORT_EN
        .abort      (abort),
`endif
        .cpu        (cpu),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_flg_in (alu_flg_in),
        .alu_cond   (alu_cond),
        .alu_q      (alu_q),
        .alu_flg_out(alu_flg_out)
    );

    // ALU model: K is carry on ADD, borrow on SUB, shifted-out bit on shifts
    always_comb begin
        r = '0;
        case (alu_op)
            5'h04: r = {1'b0, alu_a} + {1'b0, alu_b};
            5'h06: r = {1'b0, alu_a} - {1'b0, alu_b};
            5'h0A: r = {alu_b, alu_flg_in[2]};
            5'h0B: r = {alu_b[0], alu_flg_in[2], alu_b[11:1]};
            5'h0C: r = {alu_b, 1'b0};
            default: r = '0;
        endcase
        alu_q       = r[11:0];
        alu_flg_out = {2'b00, r[12], 2'b00};
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t lit(logic d, logic [11:0] a, logic [11:0] b,
                                 logic [11:0] eh, logic [11:0] el,
                                 logic ez, int lat);
        vec_t v;
        v.d = d; v.a = a; v.b = b;
        v.eh = eh; v.el = el; v.ez = ez; v.lat = lat;
        return v;
    endfunction

    function automatic vec_t mk(logic d, logic [11:0] a, logic [11:0] b);
        vec_t v;
        logic [23:0] p;
        v.d = d; v.a = a; v.b = b; v.ez = 1'b0; v.lat = 37;
        if (!d) begin
            p = {12'b0, a} * {12'b0, b};
            v.eh = p[23:12];
            v.el = p[11:0];
        end else if (b == 0) begin
            v.eh = a; v.el = 12'hFFF; v.ez = 1'b1; v.lat = 1;
        end else begin
            v.el = a / b;
            v.eh = a % b;
        end
        return v;
    endfunction

    task automatic push_exp(input string nm, input vec_t v);
        exp_t e;
        e.eh = v.eh; e.el = v.el; e.ez = v.ez; e.lat = v.lat; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic issue(input logic d, input logic [11:0] a,
                         input logic [11:0] b);
        @(negedge clk);
        cpu.start = 1'b1; cpu.op_div = d; cpu.opa = a; cpu.opb = b;
        @(posedge clk); #1;
        cpu.start = 1'b0;
    endtask

    task automatic drain(input int cyc0);
        int   cyc;
        exp_t e;
        cyc = cyc0;
        while (cpu.done !== 1'b1 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL scoreboard: done with empty queue");
            return;
        end
        e = sb.pop_front();
        chk({e.nm, ".lat"}, cyc, e.lat);
        chk({e.nm, ".hi"}, cpu.res_hi, e.eh);
        chk({e.nm, ".lo"}, cpu.res_lo, e.el);
        chk({e.nm, ".dz"}, cpu.div_zero, e.ez);
        @(posedge clk); #1;
        chk({e.nm, ".end"}, {cpu.done, cpu.busy}, 0);
        chk({e.nm, ".hold"}, {cpu.res_hi, cpu.res_lo}, {e.eh, e.el});
    endtask

    initial begin
        int   pulses;
        vec_t v;
        cpu.start = 1'b0; cpu.op_div = 1'b0;
        cpu.opa = '0; cpu.opb = '0;

        tbl.push_back(lit(0, 12'h07B, 12'h02D, 12'h001, 12'h59F, 0, 37));
        tbl.push_back(lit(0, 12'hFFF, 12'hFFF, 12'hFFE, 12'h001, 0, 37));
        tbl.push_back(lit(1, 12'h064, 12'h007, 12'h002, 12'h00E, 0, 37));
        tbl.push_back(lit(1, 12'hFFF, 12'h801, 12'h7FE, 12'h001, 0, 37));
        tbl.push_back(lit(1, 12'h123, 12'h000, 12'h123, 12'hFFF, 1, 1));
        tbl.push_back(mk(0, 12'h000, 12'h5A5));
        tbl.push_back(mk(0, 12'h800, 12'h002));
        tbl.push_back(mk(1, 12'h005, 12'h00A));
        tbl.push_back(mk(1, 12'hFFF, 12'h001));
        tbl.push_back(mk(1, 12'h800, 12'h800));
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(mk(i[0], 12'($urandom_range(0, 4095)),
                             12'($urandom_range(1, 4095))));
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", cpu.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst.done", cpu.done, 0);
        chk("rst.dz", cpu.div_zero, 0);
        chk("rst.res", {cpu.res_hi, cpu.res_lo}, 0);
        chk("rst.op", alu_op, 0);
        chk("rst.ab", {alu_a, alu_b}, 0);
        chk("rst.cond", alu_cond, 4'hF);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            push_exp($sformatf("vec%0d", i), v);
            issue(v.d, v.a, v.b);
            drain(1);
        end

        // start mid-multiply must be dropped, not queued
        push_exp("ign", lit(0, 12'h07B, 12'h02D, 12'h001, 12'h59F, 0, 37));
        issue(0, 12'h07B, 12'h02D);
        repeat (9) begin @(posedge clk); #1; end
        cpu.start = 1'b1; cpu.op_div = 1'b1;
        cpu.opa = 12'hFFF; cpu.opb = 12'h001;
        chk("ign.busy", cpu.busy, 1);
        @(posedge clk); #1;
        cpu.start = 1'b0;
        drain(11);
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (cpu.done) pulses++;
        end
        chk("ign.noq", pulses, 0);

        // reset in cycle 20 of a multiply
        issue(0, 12'hFFF, 12'hFFF);
        repeat (19) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("arst.busy", cpu.busy, 0);
        chk("arst.res", {cpu.res_hi, cpu.res_lo}, 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (45) begin
            @(posedge clk); #1;
            if (cpu.done) pulses++;
        end
        chk("arst.nodone", pulses, 0);
        chk("arst.hold", {cpu.res_hi, cpu.res_lo}, 0);

`ifdef ALU_MULDIV_ABORT_EN
        push_exp("pre", lit(0, 12'h07B, 12'h02D, 12'h001, 12'h59F, 0, 37));
        issue(0, 12'h07B, 12'h02D);
        drain(1);
        issue(1, 12'h064, 12'h007);
        repeat (4) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abt.busy", cpu.busy, 0);
        pulses = 0;
        repeat (45) begin
            @(posedge clk); #1;
            if (cpu.done) pulses++;
        end
        chk("abt.nodone", pulses, 0);
        chk("abt.res", {cpu.res_hi, cpu.res_lo}, {12'h001, 12'h59F});
        chk("abt.dz", cpu.div_zero, 0);
`endif

        chk("sb.empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer that drives the shared 12-bit ALU to run unsigned 12x12 multiply and 12/12 divide.
- Uses only existing ALU ops: ADD, SUB, SHL, RKL, RKR.
- Sits beside the ALU in the execute stage. While busy it owns the ALU input mux and the carry (K) bit path.
- The CPU issues with a start pulse, stalls on busy, and collects results on done.

Parameters:
- W, 12, datapath width; the only supported value is 12.
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > W.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- op_div  in  1  0 = multiply, 1 = divide; captured with start
- opa  in  12  multiplicand / dividend; captured with start
- opb  in  12  multiplier / divisor; captured with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- div_zero  out  1  divide-by-zero status; held until next accepted start
- res_hi  out  12  product[23:12] / remainder
- res_lo  out  12  product[11:0] / quotient
- alu_a  out  12  ALU A operand
- alu_b  out  12  ALU B operand
- alu_op  out  5  ALU operation code
- alu_flg_in  out  5  ALU flags in: K at bit 2, all other bits 0
- alu_cond  out  4  ALU condition select; tied to 4'hF
- alu_q  in  12  ALU result
- alu_flg_out  in  5  ALU flags out; only bit 2 (K) is used

Behaviour:
- Reset: state IDLE, busy=0, done=0, div_zero=0, res_hi=res_lo=0, internal K=0, count=0. In IDLE the ALU outputs are alu_op=5'h00 and alu_a=alu_b=0.
- Reset asserted mid-operation aborts immediately: no done, results cleared.
- States: IDLE, M_ADD, M_RH, M_RL, D_SHL, D_RKL, D_SUB, DONE.
- Start in IDLE:
  - Latch operands. Clear div_zero. count=0.
  - Multiply: hi=0, lo=opb, next state M_ADD.
  - Divide, opb!=0: hi=0, lo=opa, next state D_SHL.
  - Divide, opb==0: res_hi=opa, res_lo=12'hFFF, div_zero=1, next state DONE.
- Start while busy is ignored; it is not queued.
- Multiply iteration, 3 cycles:
  - M_ADD: op 5'h04, A=hi, B = lo[0] ? mcand : 0. hi<=Q, K<=K_out.
  - M_RH: op 5'h0B (RKR), B=hi, flg K=K. hi<=Q, K<=K_out.
  - M_RL: op 5'h0B, B=lo. lo<=Q. count++. If count==W-1, go to DONE, else go to M_ADD.
- Divide iteration (restoring), 3 cycles:
  - D_SHL: op 5'h0C, B=lo. lo<=Q, K<=K_out.
  - D_RKL: op 5'h0A, B=hi, flg K=K. hi_sh<=Q, ovf<=K_out.
  - D_SUB: op 5'h06, A=hi_sh, B=divisor.
    - If ovf | ~K_out: hi<=Q and lo[0]<=1.
    - Otherwise: hi<=hi_sh and lo[0] stays 0.
    - count++. Exit to DONE after W iterations.
- DONE: done=1 for exactly one cycle, res_hi=hi, res_lo=lo, busy=1. Next state IDLE.
- Latency:
  - Multiply and divide with nonzero divisor: done is high in cycle 37 after the start edge (12 x 3 + 1).
  - Divide-by-zero: done in cycle 1.
- Results hold until the next accepted start. A new start is accepted in the cycle after DONE.
- Arithmetic is modulo 2^12 for every ALU op. K and ovf are internal single-bit registers.

Optional Feature:
- Macro ALU_MULDIV_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit).
  - abort=1 in any non-IDLE state except DONE forces IDLE on the next edge.
  - No done pulse; res_hi/res_lo keep their pre-start values; div_zero=0.
  - abort in IDLE or DONE is ignored.
- When undefined: no abort port; every operation runs to completion.

Decomposition:
- Shared package alu_pkg holds:
  - 5-bit ALU opcode constants: OP_MOV, OP_ADD, OP_SUB, OP_SHL, OP_RKL, OP_RKR, etc.
  - Flag bit indices: FLG_Z=0, FLG_S=1, FLG_K=2, FLG_V=3, FLG_P=4.
  - Condition codes.
  - The sequencer state enum.
- No sub-module. The single FSM plus the hi/lo/count registers is the natural granularity.

Test Plan:
- MUL opa=12'h07B, opb=12'h02D -> done at cycle 37; res_hi=12'h001, res_lo=12'h59F.
- MUL opa=opb=12'hFFF -> res_hi=12'hFFE, res_lo=12'h001. Checks the carry-into-hi path on every iteration.
- DIV opa=12'h064, opb=12'h007 -> res_lo=12'h00E, res_hi=12'h002, div_zero=0.
- DIV opa=12'hFFF, opb=12'h801 -> res_lo=12'h001, res_hi=12'h7FE. Exercises the ovf path.
- DIV opb=0, opa=12'h123 -> done at cycle 1; div_zero=1, res_lo=12'hFFF, res_hi=12'h123.
- Start pulsed at cycle 10 of a MUL -> ignored, first result unchanged. rst at cycle 20 of a second MUL -> busy=0, done never pulses, res_hi/res_lo=0.
